imem_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer placed between the PC/branch logic and the single-port byte-addressed instruction ROM (`imem`). It issues sequential fetch addresses, captures the ROM's one-cycle-latency read data into a 2-entry buffer, and presents instructions to decode with a valid/ready handshake. It also applies redirects (branch, jump, trap) and halts with exact flush semantics. The buffer is required because `imem` zeroes its output in any cycle it is not enabled, so read data exists for exactly one cycle.

---
 rtl/imem_fetch_ctrl.sv | 119 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Instruction-fetch sequencer between the PC/branch logic and the
// instruction ROM. It issues sequential fetch addresses and captures the
// ROM's single-cycle read data into a 2-entry buffer. Instructions go to
// decode over a valid/ready handshake. Redirects flush all older work, and
// halt stops new issues while the buffer drains.

module imem_fetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,

  output logic                  imem_ena,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_dout,

  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,

  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  // Fetch pointer and the address of the read currently in flight
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;

  // Two-entry buffer of {pc, instruction}
  logic [ADDR_WIDTH-1:0] fifo_pc   [2];
  logic [DATA_WIDTH-1:0] fifo_inst [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;

  // Handshake and issue bookkeeping
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [1:0]            occupancy;
  logic [1:0]            occ_after_pop;

  // Decode handshake, issue credit and ROM request; the issue is forced off
  // while rst_n is low so the ROM sees no request during reset
  always_comb begin
    inst_valid    = (count != 2'd0);
    pop           = inst_valid & inst_ready;
    push          = inflight & ~redirect_valid;
    occupancy     = count + {1'b0, inflight};
    occ_after_pop = occupancy - {1'b0, pop};
    issue         = rst_n & ~halt &
                    (redirect_valid | (occ_after_pop < 2'd2));
    imem_ena      = issue;
    imem_addr     = redirect_valid ? redirect_pc : pc;
    inst          = '0;
    inst_pc       = '0;
    if (inst_valid) begin
      inst    = fifo_inst[rd_ptr];
      inst_pc = fifo_pc[rd_ptr];
    end
  end

  // Fetch pointer: advance past whatever was issued, or park on a redirect
  // target when halt prevents issuing it right away
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= imem_addr;
        pc          <= imem_addr + PC_STEP;
      end else if (redirect_valid) begin
        pc <= redirect_pc;
      end
    end
  end

  // Buffer pointers and occupancy; a redirect discards everything buffered
  // along with the read data arriving in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (redirect_valid) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Buffer storage captures the ROM data, which exists for one cycle only
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= inflight_pc;
      fifo_inst[wr_ptr] <= imem_dout;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios followed by random traffic,
// checked every cycle against a queue-based model of the instruction stream.

module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ena;
  logic [31:0] imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } item_t;

  item_t       q[$];
  logic [31:0] nextIssue;
  int          cyc;
  int          checks;
  int          errors;

  logic        obsEna;
  logic [31:0] obsAddr;
  logic        obsValid;
  logic [31:0] obsPc;
  logic [31:0] obsInst;

  imem_fetch_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_ena      (imem_ena),
    .imem_addr     (imem_addr),
    .imem_dout     (imem_dout),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt          (halt),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // ROM contents: the three test-plan words, then an address-derived pattern
  function automatic logic [31:0] romData(input logic [31:0] a);
    case (a)
      32'h0:   romData = 32'h0000_0013;
      32'h4:   romData = 32'h0010_0093;
      32'h8:   romData = 32'h0020_0113;
      default: romData = {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endcase
  endfunction

  // ROM model: one-cycle read latency, output zeroed when not enabled
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) imem_dout <= '0;
    else        imem_dout <= imem_ena ? romData(imem_addr) : 32'h0;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs, compare every output against the model, then
  // advance the model to the state after the coming clock edge
  task automatic applyStimulus(input logic rdy, input logic hlt,
                               input logic rv, input logic [31:0] rp);
    logic        headVis;
    logic        expPop;
    logic        expIssue;
    logic [31:0] expPc;
    logic [31:0] expInst;
    int          occ;
    item_t       it;
    @(negedge clk);
    rst_n          = 1'b1;
    inst_ready     = rdy;
    halt           = hlt;
    redirect_valid = rv;
    redirect_pc    = rp;
    #1;
    obsEna   = imem_ena;
    obsAddr  = imem_addr;
    obsValid = inst_valid;
    obsPc    = inst_pc;
    obsInst  = inst;

    headVis = 1'b0;
    expPc   = 32'h0;
    expInst = 32'h0;
    if (q.size() > 0) begin
      if (q[0].cyc <= cyc - 2) begin
        headVis = 1'b1;
        expPc   = q[0].pc;
        expInst = romData(q[0].pc);
      end
    end
    checkOutput("inst_valid", {63'b0, obsValid}, {63'b0, headVis});
    checkOutput("inst_pc", {32'b0, obsPc}, {32'b0, expPc});
    checkOutput("inst", {32'b0, obsInst}, {32'b0, expInst});

    expPop   = headVis & rdy;
    occ      = q.size() - (expPop ? 1 : 0);
    expIssue = !hlt && (rv || occ < 2);
    checkOutput("imem_ena", {63'b0, obsEna}, {63'b0, expIssue});
    checkOutput("imem_addr", {32'b0, obsAddr}, {32'b0, (rv ? rp : nextIssue)});
    checkOutput("count_inflight_le2",
                {63'b0, ((32'(dut.count) + 32'(dut.inflight)) <= 32'd2)}, 64'd1);

    if (expPop) void'(q.pop_front());
    if (rv) begin
      q.delete();
      if (expIssue) begin
        it.pc  = rp;
        it.cyc = cyc;
        q.push_back(it);
        nextIssue = rp + 32'd4;
      end else begin
        nextIssue = rp;
      end
    end else if (expIssue) begin
      it.pc  = nextIssue;
      it.cyc = cyc;
      q.push_back(it);
      nextIssue = nextIssue + 32'd4;
    end
    cyc++;
  endtask

  // Assert reset (between clock edges when mid-stream), check the reset
  // values straight away and again after a couple of edges
  task automatic resetSequence(input bit midStream);
    if (midStream) begin
      @(posedge clk);
      #2;
    end
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    inst_ready     = 1'b0;
    #1;
    checkOutput("rst_imem_ena", {63'b0, imem_ena}, 64'd0);
    checkOutput("rst_imem_addr", {32'b0, imem_addr}, 64'd0);
    checkOutput("rst_inst_valid", {63'b0, inst_valid}, 64'd0);
    checkOutput("rst_inst", {32'b0, inst}, 64'd0);
    checkOutput("rst_inst_pc", {32'b0, inst_pc}, 64'd0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_hold_ena", {63'b0, imem_ena}, 64'd0);
    checkOutput("rst_hold_valid", {63'b0, inst_valid}, 64'd0);
    q.delete();
    nextIssue = 32'h0;
    cyc       = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    resetSequence(1'b0);

    // Straight-line fetch
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      if (i == 0) begin
        checkOutput("first_issue_ena", {63'b0, obsEna}, 64'd1);
        checkOutput("first_issue_addr", {32'b0, obsAddr}, 64'd0);
      end
      if (i == 1) checkOutput("c1_not_valid", {63'b0, obsValid}, 64'd0);
      if (i == 2) begin
        checkOutput("c2_pc", {32'b0, obsPc}, 64'h0);
        checkOutput("c2_inst", {32'b0, obsInst}, 64'h0000_0013);
      end
    end

    // Stall for 5 cycles while the pc=4 instruction is at the head
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      if (i == 0) checkOutput("stall_head_inst", {32'b0, obsInst}, 64'h0010_0093);
      if (i == 4) begin
        checkOutput("stall_ena_low", {63'b0, obsEna}, 64'd0);
        checkOutput("stall_count2", {62'b0, dut.count}, 64'd2);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("release_pc4", {32'b0, obsPc}, 64'h4);
    checkOutput("release_reissue", {63'b0, obsEna}, 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("release_pc8", {32'b0, obsPc}, 64'h8);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("release_pcC", {32'b0, obsPc}, 64'hC);

    // Redirect under load: fill the buffer, then redirect with a pop
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_flushed", {63'b0, obsValid}, 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_pc40", {32'b0, obsPc}, 64'h40);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_pc44", {32'b0, obsPc}, 64'h44);

    // Halt for 4 cycles, then resume at the next sequential pc
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("halt_no_issue", {63'b0, obsEna}, 64'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("halt_resume_addr", {32'b0, obsAddr}, 64'h50);

    // Redirect together with halt
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h80);
    checkOutput("redir_halt_ena", {63'b0, obsEna}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("redir_halt_empty", {63'b0, obsValid}, 64'd0);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_halt_resume", {32'b0, obsAddr}, 64'h80);

    // Address wrap
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_addr", {32'b0, obsAddr}, 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_head", {32'b0, obsPc}, 64'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_next", {32'b0, obsPc}, 64'h0);

    // Reset mid-stream
    resetSequence(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_restart_ena", {63'b0, obsEna}, 64'd1);
    checkOutput("rst_restart_addr", {32'b0, obsAddr}, 64'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic        rdy;
      logic        hlt;
      logic        rv;
      logic [31:0] rp;
      rdy = ($urandom_range(0, 3) != 0);
      hlt = ($urandom_range(0, 9) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) rp = 32'hFFFF_FFF0 | ($urandom & 32'hC);
      else                           rp = $urandom & 32'h0000_0FFC;
      if (i == 1500) resetSequence(1'b1);
      applyStimulus(rdy, hlt, rv, rp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
